// File: rtl/bandai_eeprom_i2c.sv
// ----------------------------------------------------------------------------
// bandai_eeprom_i2c
// 24C02-class serial EEPROM emulator sitting behind the Bandai FCG/LZ93D50
// register decoder. The mapper passes the SCL/SDA levels written by the CPU.
// This block returns the open-drain SDA drive, which the mapper folds into
// the CPU read data. Byte storage is external save memory, reached through
// a simple synchronous port.
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   rst       synchronous active-high reset
//   scl       SCL level from the mapper register
//   sda_in    SDA level driven by the host
//   sda_out   device SDA drive (1 = released, 0 = pull low)
//   mem_addr  byte address to save memory
//   mem_we    one-clock write strobe
//   mem_dout  write data
//   mem_re    one-clock read strobe
//   mem_din   read data, valid one clock after mem_re
//   busy      high whenever the protocol engine is not idle
// ----------------------------------------------------------------------------
module bandai_eeprom_i2c #(
   parameter int unsigned AW        = 8,
   parameter int unsigned PAGE_BITS = 3,
   parameter logic [3:0]  DEV_ID    = 4'b1010
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl,
   input  logic          sda_in,
   output logic          sda_out,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [7:0]    mem_dout,
   output logic          mem_re,
   input  logic [7:0]    mem_din,
   output logic          busy
);

   typedef enum logic [3:0] {
      IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;

   state_t        state, state_nx;
   logic          scl_q, sda_q;
   logic [3:0]    bit_cnt;
   logic [7:0]    sr;        // incoming byte
   logic [7:0]    rd_sr;     // outgoing byte, MSB is the next bit to drive
   logic [AW-1:0] ptr;
   logic          wr_pend;   // byte complete, write strobe fires next clock
   logic          rd_lat;    // mem_din holds the requested byte this clock

   logic scl_rise, scl_fall, start_det, stop_det, bus_cond;
   logic bit_full, shift_st, dev_match;
   logic sda_nx, re_nx, rd_ack;

   assign scl_rise  = scl & ~scl_q;
   assign scl_fall  = ~scl & scl_q;
   // START/STOP need SCL high on both sides of the SDA transition
   assign start_det = scl & scl_q & sda_q & ~sda_in;
   assign stop_det  = scl & scl_q & ~sda_q & sda_in;
   assign bus_cond  = start_det | stop_det;
   assign bit_full  = (bit_cnt == 4'd8);
   assign shift_st  = (state == DEV) || (state == WADDR) || (state == WDATA);
   assign dev_match = (sr[7:4] == DEV_ID);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      if (start_det)      state_nx = DEV;
      else if (stop_det)  state_nx = IDLE;
      else begin
         case (state)
            DEV:       if (scl_fall && bit_full) state_nx = dev_match ? DEV_ACK : IDLE;
            DEV_ACK:   if (scl_fall) state_nx = sr[0] ? RDATA : WADDR;
            WADDR:     if (scl_fall && bit_full) state_nx = WADDR_ACK;
            WADDR_ACK: if (scl_fall) state_nx = WDATA;
            WDATA:     if (scl_fall && bit_full) state_nx = WDATA_ACK;
            WDATA_ACK: if (scl_fall) state_nx = WDATA;
            RDATA:     if (scl_fall && bit_full) state_nx = RDATA_ACK;
            RDATA_ACK: if (scl_rise) state_nx = sda_in ? IDLE : RDATA;
            default:   state_nx = IDLE;
         endcase
      end
   end

   // output decode: next SDA drive and read-strobe requests
   always_comb begin
      sda_nx = sda_out;
      re_nx  = 1'b0;
      rd_ack = 1'b0;
      busy   = (state != IDLE);
      if (bus_cond) begin
         sda_nx = 1'b1;
      end else begin
         case (state)
            DEV: if (scl_fall && bit_full && dev_match) begin
               sda_nx = 1'b0;
               // read request: fetch now so the byte is ready before the ACK ends
               re_nx  = sr[0];
            end
            WADDR, WDATA:         if (scl_fall && bit_full) sda_nx = 1'b0;
            DEV_ACK:              if (scl_fall) sda_nx = sr[0] ? rd_sr[7] : 1'b1;
            WADDR_ACK, WDATA_ACK: if (scl_fall) sda_nx = 1'b1;
            RDATA:                if (scl_fall) sda_nx = bit_full ? 1'b1 : rd_sr[7];
            RDATA_ACK: if (scl_rise && !sda_in) begin
               rd_ack = 1'b1;
               re_nx  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // control registers and memory port
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
         bit_cnt  <= '0;
         ptr      <= '0;
         wr_pend  <= 1'b0;
         rd_lat   <= 1'b0;
         sda_out  <= 1'b1;
         mem_we   <= 1'b0;
         mem_re   <= 1'b0;
         mem_addr <= '0;
         mem_dout <= '0;
      end else begin
         scl_q   <= scl;
         sda_q   <= sda_in;
         sda_out <= sda_nx;
         mem_re  <= re_nx;
         mem_we  <= 1'b0;
         rd_lat  <= mem_re;
         if (re_nx) mem_addr <= rd_ack ? ptr + 1'b1 : ptr;
         if (wr_pend) begin
            mem_we   <= 1'b1;
            mem_addr <= ptr;
            mem_dout <= sr;
            // page write: only the low PAGE_BITS advance
            ptr      <= {ptr[AW-1:PAGE_BITS], ptr[PAGE_BITS-1:0] + 1'b1};
            wr_pend  <= 1'b0;
         end
         if (rd_ack) ptr <= ptr + 1'b1;
         if (start_det) begin
            bit_cnt <= '0;
         end else if (!stop_det) begin
            if (scl_rise && !bit_full && (shift_st || state == RDATA)) begin
               bit_cnt <= bit_cnt + 1'b1;
               if (state == WDATA && bit_cnt == 4'd7) wr_pend <= 1'b1;
            end
            if (scl_fall) begin
               case (state)
                  WADDR:                         if (bit_full) ptr <= AW'(sr);
                  DEV_ACK, WADDR_ACK, WDATA_ACK: bit_cnt <= '0;
                  default: ;
               endcase
            end
            if (rd_ack) bit_cnt <= '0;
         end
      end
   end

   // byte shifters (data path, no reset)
   always_ff @(posedge clk) begin
      if (rd_lat) rd_sr <= mem_din;
      if (!bus_cond) begin
         if (scl_rise && !bit_full && shift_st) sr <= {sr[6:0], sda_in};
         if (scl_fall && ((state == DEV_ACK && sr[0]) || (state == RDATA && !bit_full)))
            rd_sr <= {rd_sr[6:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_bandai_eeprom_i2c.sv
module tb_bandai_eeprom_i2c;

   logic       clk = 1'b0;
   logic       rst, scl, sda_in;
   logic       sda_out, mem_we, mem_re, busy;
   logic [7:0] mem_addr, mem_dout;
   logic [7:0] mem_din = 8'h00;
   logic [7:0] mem [256];

   int n_chk = 0, n_pass = 0;
   int we_n = 0, re_n = 0, both_n = 0;
   logic [7:0] we_a [16];
   logic [7:0] we_d [16];
   logic [7:0] re_a [16];
   logic lo_seen = 1'b0;

   bandai_eeprom_i2c #(.AW(8), .PAGE_BITS(3), .DEV_ID(4'b1010)) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in), .sda_out(sda_out),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout),
      .mem_re(mem_re), .mem_din(mem_din), .busy(busy)
   );

   always #5 clk = ~clk;

   // save memory model: read data one clock after mem_re
   always @(posedge clk) begin
      if (mem_re) mem_din <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_dout;
   end

   // strobe log
   always @(negedge clk) begin
      if (mem_we) begin
         if (we_n < 16) begin we_a[we_n] = mem_addr; we_d[we_n] = mem_dout; end
         we_n++;
      end
      if (mem_re) begin
         if (re_n < 16) re_a[re_n] = mem_addr;
         re_n++;
      end
      if (mem_we && mem_re) both_n++;
      if (!sda_out) lo_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_in = 1'b1; hold(2);
      scl = 1'b1;    hold(4);
      sda_in = 1'b0; hold(4);
      scl = 1'b0;    hold(4);
   endtask

   task automatic i2c_stop();
      sda_in = 1'b0; hold(2);
      scl = 1'b1;    hold(4);
      sda_in = 1'b1; hold(4);
   endtask

   task automatic send_bit(input logic b);
      sda_in = b; hold(2);
      scl = 1'b1; hold(4);
      scl = 1'b0; hold(2);
   endtask

   // host sends a byte, returns the level seen on SDA in the ACK slot
   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_in = 1'b1; hold(2);
      scl = 1'b1;    hold(2);
      ack = sda_in & sda_out;
      hold(2);
      scl = 1'b0;    hold(2);
   endtask

   // host reads a byte and answers with ack (0 = ACK, 1 = NACK)
   task automatic recv_byte(input logic ack, output logic [7:0] b);
      logic [7:0] v;
      v = 8'h00;
      sda_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         hold(2);
         scl = 1'b1; hold(2);
         v = {v[6:0], sda_in & sda_out};
         hold(2);
         scl = 1'b0;
      end
      hold(2);
      sda_in = ack; hold(2);
      scl = 1'b1;   hold(4);
      scl = 1'b0;   hold(2);
      sda_in = 1'b1;
      b = v;
   endtask

   initial begin
      logic       a;
      logic [7:0] d;
      int         we0, re0;

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'hFF] = 8'hA5;

      // reset state
      rst = 1'b1; scl = 1'b1; sda_in = 1'b1;
      hold(3);
      chk("rst_sda_out", sda_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_re", mem_re, 1'b0);
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_mem_dout", mem_dout, 8'h00);
      rst = 1'b0;
      hold(4);

      // page write starting at 0x05, fourth byte wraps to 0x00
      i2c_start();
      send_byte(8'hA0, a); chk("wr_ack_dev", a, 1'b0);
      send_byte(8'h05, a); chk("wr_ack_addr", a, 1'b0);
      send_byte(8'h11, a); chk("wr_ack_d0", a, 1'b0);
      send_byte(8'h22, a); chk("wr_ack_d1", a, 1'b0);
      send_byte(8'h33, a); chk("wr_ack_d2", a, 1'b0);
      send_byte(8'h44, a); chk("wr_ack_d3", a, 1'b0);
      i2c_stop();
      hold(4);
      chk("wr_count", we_n, 4);
      chk("wr0_addr", we_a[0], 8'h05); chk("wr0_data", we_d[0], 8'h11);
      chk("wr1_addr", we_a[1], 8'h06); chk("wr1_data", we_d[1], 8'h22);
      chk("wr2_addr", we_a[2], 8'h07); chk("wr2_data", we_d[2], 8'h33);
      chk("wr3_addr", we_a[3], 8'h00); chk("wr3_data", we_d[3], 8'h44);
      chk("wr_busy_after_stop", busy, 1'b0);

      // random read from 0x06 through a repeated START
      re0 = re_n;
      i2c_start();
      send_byte(8'hA0, a); chk("rr_ack_dev", a, 1'b0);
      send_byte(8'h06, a); chk("rr_ack_addr", a, 1'b0);
      i2c_start();
      send_byte(8'hA1, a); chk("rr_ack_dev_rd", a, 1'b0);
      recv_byte(1'b0, d);  chk("rr_byte0", d, 8'h22);
      recv_byte(1'b1, d);  chk("rr_byte1", d, 8'h33);
      i2c_stop();
      hold(4);
      chk("rr_busy_after_stop", busy, 1'b0);
      chk("rr_re_count", re_n - re0, 2);
      chk("rr_re0_addr", re_a[re0], 8'h06);
      chk("rr_re1_addr", re_a[re0 + 1], 8'h07);

      // current-address read shows the pointer stayed at 0x07
      re0 = re_n;
      i2c_start();
      send_byte(8'hA1, a); chk("cur_ack_dev", a, 1'b0);
      recv_byte(1'b1, d);  chk("cur_byte", d, 8'h33);
      i2c_stop();
      hold(4);
      chk("cur_re_addr", re_a[re0], 8'h07);

      // sequential read wrapping 0xFF -> 0x00
      we0 = we_n;
      i2c_start();
      send_byte(8'hA0, a); chk("wrap_ack_dev", a, 1'b0);
      send_byte(8'hFF, a); chk("wrap_ack_addr", a, 1'b0);
      i2c_stop();
      hold(4);
      re0 = re_n;
      i2c_start();
      send_byte(8'hA1, a); chk("wrap_ack_dev_rd", a, 1'b0);
      recv_byte(1'b0, d);  chk("wrap_byte0", d, 8'hA5);
      recv_byte(1'b1, d);  chk("wrap_byte1", d, 8'h44);
      i2c_stop();
      hold(4);
      chk("wrap_re_count", re_n - re0, 2);
      chk("wrap_re0_addr", re_a[re0], 8'hFF);
      chk("wrap_re1_addr", re_a[re0 + 1], 8'h00);
      chk("wrap_no_write", we_n - we0, 0);

      // wrong device type: no ACK, back to idle, no strobes
      we0 = we_n; re0 = re_n;
      i2c_start();
      lo_seen = 1'b0;
      send_byte(8'h50, a);
      chk("nodev_ack", a, 1'b1);
      chk("nodev_never_low", lo_seen, 1'b0);
      chk("nodev_busy", busy, 1'b0);
      i2c_stop();
      hold(4);
      chk("nodev_we", we_n - we0, 0);
      chk("nodev_re", re_n - re0, 0);

      // STOP in the middle of the address byte
      we0 = we_n;
      i2c_start();
      send_byte(8'hA0, a); chk("mid_ack_dev", a, 1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      hold(4);
      chk("mid_busy", busy, 1'b0);
      chk("mid_no_write", we_n - we0, 0);
      re0 = re_n;
      i2c_start();
      send_byte(8'hA1, a);
      recv_byte(1'b1, d);  chk("mid_ptr_byte", d, 8'h44);
      i2c_stop();
      hold(4);
      chk("mid_ptr_addr", re_a[re0], 8'h00);

      // reset after the 5th data bit of a write
      we0 = we_n;
      i2c_start();
      send_byte(8'hA0, a); chk("rw_ack_dev", a, 1'b0);
      send_byte(8'h10, a); chk("rw_ack_addr", a, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      rst = 1'b1;
      hold(1);
      chk("rw_sda_out", sda_out, 1'b1);
      chk("rw_busy", busy, 1'b0);
      chk("rw_mem_we", mem_we, 1'b0);
      chk("rw_mem_re", mem_re, 1'b0);
      chk("rw_mem_addr", mem_addr, 8'h00);
      chk("rw_mem_dout", mem_dout, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      send_bit(1'b1);
      i2c_stop();
      hold(6);
      chk("rw_no_write", we_n - we0, 0);
      chk("rw_busy_end", busy, 1'b0);

      chk("strobes_exclusive", both_n, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
